// File: rtl/audio_tdm_tx.sv
// Serial audio transmitter: frame FIFO feeding an I2S / left-justified / TDM serialiser.
// Define AUDIO_TDM_TX_UNDERRUN_CNT_EN to build the saturating underrun counter.
module audio_tdm_tx #(
  parameter int unsigned SAMPLE_WIDTH = 32,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned BCK_DIV      = 4,
  parameter int unsigned MODE         = 0
) (
  input  logic                             clk,
  input  logic                             aclr_n,
  input  logic                             en,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] sample,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]      level,
  output logic                             underrun,
  output logic [15:0]                      underrun_cnt,
  output logic                             bck,
  output logic                             lrclk,
  output logic                             dout
);

  localparam int unsigned F  = CHANNELS * SAMPLE_WIDTH;
  localparam int unsigned PW = $clog2(F);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e         state_q, state_d;
  logic [F-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]  level_q, level_d;
  logic           wr_ready_q;
  logic           push, pop;

  logic [DW-1:0]  div_q, div_d;
  logic [PW-1:0]  pos_q, pos_d, q_pos;
  logic [F-1:0]   shift_q, shift_d;
  logic [F-1:0]   frame_ser;
  logic           bck_q, bck_d, lrclk_q, lrclk_d, dout_q, dout_d;
  logic           underrun_q, underrun_d;
  logic           fall, load;

  assign push = wr_valid && wr_ready_q;

  // Head frame reordered so that channel 0's MSB sits at the top of the shifter.
  always_comb begin
    frame_ser = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      frame_ser[F-1-c*SAMPLE_WIDTH -: SAMPLE_WIDTH] = mem[rd_ptr_q][c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    pos_d      = pos_q;
    shift_d    = shift_q;
    bck_d      = bck_q;
    lrclk_d    = lrclk_q;
    dout_d     = dout_q;
    underrun_d = 1'b0;
    fall       = 1'b0;
    load       = 1'b0;
    pop        = 1'b0;
    q_pos      = '0;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StRun;
          pos_d   = '0;
          fall    = 1'b1;
          load    = 1'b1;
        end
      end
      StRun: begin
        if (div_q == DW'(BCK_DIV - 1)) begin
          div_d = '0;
          if (!bck_q) begin
            bck_d = 1'b1;
          end else if (pos_q == PW'(F - 1)) begin
            pos_d = '0;
            if (en) begin
              fall = 1'b1;
              load = 1'b1;
            end else begin
              state_d = StIdle;
              bck_d   = 1'b0;
              lrclk_d = 1'b0;
              dout_d  = 1'b0;
            end
          end else begin
            pos_d = pos_q + 1'b1;
            fall  = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (fall) begin
      bck_d = 1'b0;
      div_d = '0;
      if (load) begin
        // Emptiness is judged on the registered level, so a same-cycle push cannot mask it.
        pop        = (level_q != '0);
        underrun_d = (level_q == '0);
        shift_d    = pop ? {frame_ser[F-2:0], 1'b0} : '0;
        dout_d     = pop ? frame_ser[F-1] : 1'b0;
      end else begin
        shift_d = {shift_q[F-2:0], 1'b0};
        dout_d  = shift_q[F-1];
      end
      if (MODE == 1) begin
        q_pos = pos_d;
      end else begin
        q_pos = (pos_d == PW'(F - 1)) ? '0 : pos_d + 1'b1;
      end
      if (CHANNELS == 2) begin
        lrclk_d = (q_pos >= PW'(SAMPLE_WIDTH));
      end else begin
        lrclk_d = (q_pos == '0);
      end
    end
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= sample;
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      wr_ready_q <= 1'b1;
      div_q      <= '0;
      pos_q      <= '0;
      shift_q    <= '0;
      bck_q      <= 1'b0;
      lrclk_q    <= 1'b0;
      dout_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      wr_ready_q <= (level_d < LW'(FIFO_DEPTH));
      div_q      <= div_d;
      pos_q      <= pos_d;
      shift_q    <= shift_d;
      bck_q      <= bck_d;
      lrclk_q    <= lrclk_d;
      dout_q     <= dout_d;
      underrun_q <= underrun_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

`ifdef AUDIO_TDM_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      ucnt_q <= '0;
    end else if (underrun_d && (ucnt_q != 16'hFFFF)) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end

  assign underrun_cnt = ucnt_q;
`else
  assign underrun_cnt = 16'h0000;
`endif

  assign wr_ready = wr_ready_q;
  assign level    = level_q;
  assign underrun = underrun_q;
  assign bck      = bck_q;
  assign lrclk    = lrclk_q;
  assign dout     = dout_q;

endmodule

// File: tb/tb_audio_tdm_tx.sv
// Scoreboard bench for audio_tdm_tx: stereo I2S, left-justified and 4-slot TDM instances.
module tb_audio_tdm_tx;

  localparam logic [31:0] LR_I2S = 32'h0001FFFE;
  localparam logic [31:0] LR_LJ  = 32'h0000FFFF;
  localparam logic [31:0] LR_TDM = 32'h00000001;
`ifdef AUDIO_TDM_TX_UNDERRUN_CNT_EN
  localparam int EXP_UCNT = 3;
`else
  localparam int EXP_UCNT = 0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] lr;
  } frame_t;

  logic        clk = 1'b0;
  logic        aclr_n;
  logic [31:0] sample;
  logic [2:0]  en, wr_valid, wr_ready, underrun, bck, lrclk, dout;
  logic [2:0]  level [3];
  logic [15:0] ucnt [3];

  always #5 clk = ~clk;

  audio_tdm_tx #(.SAMPLE_WIDTH(16), .CHANNELS(2), .FIFO_DEPTH(4), .BCK_DIV(2), .MODE(0)) u_i2s (
    .clk(clk), .aclr_n(aclr_n), .en(en[0]), .sample(sample), .wr_valid(wr_valid[0]),
    .wr_ready(wr_ready[0]), .level(level[0]), .underrun(underrun[0]),
    .underrun_cnt(ucnt[0]), .bck(bck[0]), .lrclk(lrclk[0]), .dout(dout[0])
  );

  audio_tdm_tx #(.SAMPLE_WIDTH(16), .CHANNELS(2), .FIFO_DEPTH(4), .BCK_DIV(2), .MODE(1)) u_lj (
    .clk(clk), .aclr_n(aclr_n), .en(en[1]), .sample(sample), .wr_valid(wr_valid[1]),
    .wr_ready(wr_ready[1]), .level(level[1]), .underrun(underrun[1]),
    .underrun_cnt(ucnt[1]), .bck(bck[1]), .lrclk(lrclk[1]), .dout(dout[1])
  );

  audio_tdm_tx #(.SAMPLE_WIDTH(8), .CHANNELS(4), .FIFO_DEPTH(4), .BCK_DIV(2), .MODE(0)) u_tdm (
    .clk(clk), .aclr_n(aclr_n), .en(en[2]), .sample(sample), .wr_valid(wr_valid[2]),
    .wr_ready(wr_ready[2]), .level(level[2]), .underrun(underrun[2]),
    .underrun_cnt(ucnt[2]), .bck(bck[2]), .lrclk(lrclk[2]), .dout(dout[2])
  );

  frame_t exp_q [$];
  int     n_tests = 0;
  int     n_fail = 0;
  int     frames_seen = 0;
  int     urun_seen = 0;
  int     sel = 0;
  logic   m_bck, m_dout, m_lr, m_ur;

  always_comb begin
    m_bck  = bck[sel];
    m_dout = dout[sel];
    m_lr   = lrclk[sel];
    m_ur   = underrun[sel];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Monitor: captures one bit per bck rising edge and scores each completed frame.
  logic [31:0] sh_d = '0, sh_l = '0;
  int          nbits = 0, gap = 0, bad_gap = 0;
  logic        bck_prev = 1'b0;
  frame_t      got_exp;

  always @(negedge clk) begin
    gap++;
    if (!aclr_n) begin
      nbits    = 0;
      bad_gap  = 0;
      bck_prev = 1'b0;
    end else begin
      if (m_ur) urun_seen++;
      if (m_bck && !bck_prev) begin
        if (nbits != 0 && gap != 4) bad_gap = gap;
        gap  = 0;
        sh_d = {sh_d[30:0], m_dout};
        sh_l = {sh_l[30:0], m_lr};
        nbits++;
        if (nbits == 32) begin
          nbits = 0;
          frames_seen++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_unexpected: got data %h, required no frame", sh_d);
          end else begin
            got_exp = exp_q.pop_front();
            check("frame_data", sh_d, got_exp.data);
            check("frame_lrclk", sh_l, got_exp.lr);
            check("bck_period", bad_gap, 0);
            bad_gap = 0;
          end
        end
      end
      bck_prev = m_bck;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [31:0] s, input logic [31:0] d,
                      input logic [31:0] lr, input bit expect_it);
    frame_t e;
    sample      = s;
    wr_valid[i] = 1'b1;
    tick();
    wr_valid[i] = 1'b0;
    if (expect_it) begin
      e.data = d;
      e.lr   = lr;
      exp_q.push_back(e);
    end
  endtask

  // which: 0 = completed frames, 1 = underrun pulses
  task automatic wait_count(input int which, input int target);
    int t = 0;
    while (((which == 0) ? frames_seen : urun_seen) < target && t < 3000) begin
      tick();
      t++;
    end
    if (((which == 0) ? frames_seen : urun_seen) < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_count%0d: got %0d, required %0d", which,
               (which == 0) ? frames_seen : urun_seen, target);
    end
  endtask

  task automatic check_idle(input int i, input int lvl);
    check("idle_bck", bck[i], 0);
    check("idle_lrclk", lrclk[i], 0);
    check("idle_dout", dout[i], 0);
    check("idle_underrun", underrun[i], 0);
    check("idle_level", level[i], lvl);
  endtask

  logic [31:0] fill_s [5] = '{32'h1111_2222, 32'h8000_0001, 32'hFFFF_0000,
                              32'h0F0F_F0F0, 32'hDEAD_BEEF};
  logic [31:0] fill_e [5] = '{32'h2222_1111, 32'h0001_8000, 32'h0000_FFFF,
                              32'hF0F0_0F0F, 32'h0000_0000};
  int base_f, base_u, zeros;
  frame_t uf;

  initial begin
    aclr_n   = 1'b0;
    en       = '0;
    wr_valid = '0;
    sample   = '0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check_idle(i, 0);
      check("reset_wr_ready", wr_ready[i], 1);
      check("reset_ucnt", ucnt[i], 0);
    end
    aclr_n = 1'b1;
    tick();

    // I2S: two frames, then underruns until en drops mid-frame
    sel = 0;
    push(0, 32'h1234_A5C3, 32'hA5C3_1234, LR_I2S, 1'b1);
    push(0, 32'h5555_AAAA, 32'hAAAA_5555, LR_I2S, 1'b1);
    check("level_two", level[0], 2);
    uf.data = '0;
    uf.lr   = LR_I2S;
    repeat (3) exp_q.push_back(uf);
    base_f = frames_seen;
    base_u = urun_seen;
    en[0]  = 1'b1;
    zeros  = 0;
    tick();
    while (bck[0] == 1'b0 && zeros < 10) begin
      zeros++;
      tick();
    end
    check("first_bck_rise", zeros, 2);
    wait_count(1, base_u + 3);
    repeat (10) tick();
    en[0] = 1'b0;
    push(0, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b0);
    wait_count(0, base_f + 5);
    repeat (20) tick();
    check_idle(0, 1);
    check("underrun_pulses", urun_seen - base_u, 3);
    check("underrun_cnt", ucnt[0], EXP_UCNT);
    check("queue_empty_i2s", exp_q.size(), 0);

    // Reset, fill past capacity, then drain four frames
    aclr_n = 1'b0;
    tick();
    check_idle(0, 0);
    check("reset_ucnt_again", ucnt[0], 0);
    aclr_n = 1'b1;
    tick();
    base_u = urun_seen;
    wr_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample = fill_s[i];
      tick();
      if (i < 4) begin
        uf.data = fill_e[i];
        uf.lr   = LR_I2S;
        exp_q.push_back(uf);
      end
      if (i == 3) check("full_wr_ready", wr_ready[0], 0);
    end
    wr_valid[0] = 1'b0;
    check("full_level", level[0], 4);
    base_f = frames_seen;
    en[0]  = 1'b1;
    wait_count(0, base_f + 3);
    repeat (10) tick();
    en[0] = 1'b0;
    wait_count(0, base_f + 4);
    repeat (20) tick();
    check_idle(0, 0);
    check("drain_wr_ready", wr_ready[0], 1);
    check("no_underrun_drain", urun_seen - base_u, 0);

    // Left-justified single frame
    sel    = 1;
    base_f = frames_seen;
    push(1, 32'h1234_A5C3, 32'hA5C3_1234, LR_LJ, 1'b1);
    en[1] = 1'b1;
    repeat (10) tick();
    en[1] = 1'b0;
    wait_count(0, base_f + 1);
    repeat (20) tick();
    check_idle(1, 0);
    check("queue_empty_lj", exp_q.size(), 0);

    // TDM: one full frame, then reset in the middle of the second
    sel    = 2;
    base_f = frames_seen;
    push(2, 32'h4433_2211, 32'h1122_3344, LR_TDM, 1'b1);
    push(2, 32'h8877_6655, 32'h5566_7788, LR_TDM, 1'b1);
    en[2] = 1'b1;
    wait_count(0, base_f + 1);
    repeat (10) tick();
    push(2, 32'h0102_0304, 32'h0, 32'h0, 1'b0);
    check("tdm_level", level[2], 1);
    repeat (30) tick();
    en[2]  = 1'b0;
    aclr_n = 1'b0;
    exp_q.delete();
    #1;
    check_idle(2, 0);
    check("tdm_reset_wr_ready", wr_ready[2], 1);
    tick();
    aclr_n = 1'b1;
    repeat (20) tick();
    check_idle(2, 0);
    check("tdm_frames_after_reset", frames_seen - base_f, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
